// File: rtl/cv32e40p_pkg.sv
// Shared types for the TMR voter manager: voting-mode encoding.
// Latency: n/a (types only).  Backpressure: n/a.
package cv32e40p_pkg;

    typedef enum logic [1:0] {
        TMR_FULL = 2'b00,
        TMR_DMR  = 2'b01,
        TMR_FAIL = 2'b10
    } tmr_mode_e;

endpackage

// File: rtl/voter.sv
// Bitwise 2-of-3 majority with per-replica disagreement flags.
// Latency: combinational.  Backpressure: none.
module voter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
    input  logic [WIDTH-1:0] in3_i,
    output logic [WIDTH-1:0] vote_o,
    output logic [2:0]       mismatch_o
);

    always_comb begin
        vote_o        = (in1_i & in2_i) | (in1_i & in3_i) | (in2_i & in3_i);
        mismatch_o[0] = (in1_i != vote_o);
        mismatch_o[1] = (in2_i != vote_o);
        mismatch_o[2] = (in3_i != vote_o);
    end

endmodule

// File: rtl/cv32e40p_tmr_voter_mgr.sv
// TMR voter with mismatch attribution, channel retirement and TMR->DMR->FAIL degradation.
// Latency: vote_o/fault_o combinational; status registered one cycle after the valid sample.
// Backpressure: none; every valid sample is consumed, valid_i low freezes bookkeeping.
module cv32e40p_tmr_voter_mgr
    import cv32e40p_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned PERM_THRESH = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
    input  logic [WIDTH-1:0] in3_i,
    output logic [WIDTH-1:0] vote_o,
    output logic             fault_o,
    output logic             uncorrectable_o,
    output logic [2:0]       ch_fail_o,
    output tmr_mode_e        mode_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    // Counters only ever hold 0..PERM_THRESH-1: reaching the threshold retires and clears.
    localparam int unsigned CW = (PERM_THRESH > 1) ? $clog2(PERM_THRESH) : 1;
    localparam logic [CW-1:0] THR_M1 = CW'(PERM_THRESH - 1);

    tmr_mode_e              mode_q, mode_d;
    logic [2:0]             ch_fail_q, ch_fail_d;
    logic [2:0][CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]          pair_cnt_q, pair_cnt_d;
    logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;
    logic                   unc_q, unc_d;

    logic [WIDTH-1:0]       maj;
    logic [2:0]             mis;
    logic [1:0]             n_mis;
    logic [WIDTH-1:0]       hp_a, hp_b;

    voter #(.WIDTH(WIDTH)) u_voter (
        .in1_i      (in1_i),
        .in2_i      (in2_i),
        .in3_i      (in3_i),
        .vote_o     (maj),
        .mismatch_o (mis)
    );

    always_comb begin
        // Healthy pair in index order; hp_a is the lowest-index survivor.
        if (ch_fail_q[0]) begin
            hp_a = in2_i;
            hp_b = in3_i;
        end else if (ch_fail_q[1]) begin
            hp_a = in1_i;
            hp_b = in3_i;
        end else begin
            hp_a = in1_i;
            hp_b = in2_i;
        end

        if (mode_q == TMR_FULL) begin
            vote_o  = maj;
            fault_o = |mis;
        end else begin
            vote_o  = hp_a;
            fault_o = (hp_a != hp_b);
        end

        n_mis = {1'b0, mis[0]} + {1'b0, mis[1]} + {1'b0, mis[2]};
    end

    always_comb begin
        mode_d     = mode_q;
        ch_fail_d  = ch_fail_q;
        cnt_d      = cnt_q;
        pair_cnt_d = pair_cnt_q;
        err_cnt_d  = err_cnt_q;
        unc_d      = 1'b0;

        if (clear_i) begin
            mode_d     = TMR_FULL;
            ch_fail_d  = 3'b000;
            cnt_d      = '0;
            pair_cnt_d = '0;
            err_cnt_d  = '0;
        end else if (valid_i) begin
            if (fault_o && (err_cnt_q != {CNT_W{1'b1}})) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end

            unique case (mode_q)
                TMR_FULL: begin
                    if (n_mis == 2'd0) begin
                        cnt_d = '0;
                    end else if (n_mis == 2'd1) begin
                        for (int k = 0; k < 3; k++) begin
                            if (!mis[k]) begin
                                cnt_d[k] = '0;
                            end else if (cnt_q[k] == THR_M1) begin
                                ch_fail_d[k] = 1'b1;
                                mode_d       = TMR_DMR;
                            end else begin
                                cnt_d[k] = cnt_q[k] + 1'b1;
                            end
                        end
                        if (mode_d == TMR_DMR) begin
                            cnt_d = '0;
                        end
                    end else begin
                        // Multi-channel divergence: no attribution possible, counters hold.
                        unc_d = 1'b1;
                    end
                end
                TMR_DMR: begin
                    if (fault_o) begin
                        unc_d = 1'b1;
                        if (pair_cnt_q == THR_M1) begin
                            mode_d     = TMR_FAIL;
                            pair_cnt_d = '0;
                        end else begin
                            pair_cnt_d = pair_cnt_q + 1'b1;
                        end
                    end else begin
                        pair_cnt_d = '0;
                    end
                end
                TMR_FAIL: begin
                    unc_d = fault_o;
                end
                default: begin
                    mode_d = TMR_FAIL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q     <= TMR_FULL;
            ch_fail_q  <= 3'b000;
            cnt_q      <= '0;
            pair_cnt_q <= '0;
            err_cnt_q  <= '0;
            unc_q      <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            ch_fail_q  <= ch_fail_d;
            cnt_q      <= cnt_d;
            pair_cnt_q <= pair_cnt_d;
            err_cnt_q  <= err_cnt_d;
            unc_q      <= unc_d;
        end
    end

    assign uncorrectable_o = unc_q;
    assign ch_fail_o       = ch_fail_q;
    assign mode_o          = mode_q;
    assign err_cnt_o       = err_cnt_q;

endmodule

// File: tb/tb_cv32e40p_tmr_voter_mgr.sv
// Bench for cv32e40p_tmr_voter_mgr: vector table with a status scoreboard, plus
// hand sequences for reset mid-degradation and a CNT_W=2 / PERM_THRESH=1 instance.
module tb_cv32e40p_tmr_voter_mgr;
    import cv32e40p_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, valid_i, clear_i;
    logic [31:0] in1, in2, in3;
    logic [31:0] vote;
    logic        fault, unc;
    logic [2:0]  ch_fail;
    tmr_mode_e   mode;
    logic [7:0]  err_cnt;

    logic        b_valid, b_clear;
    logic [31:0] b_in1, b_in2, b_in3;
    logic [31:0] b_vote;
    logic        b_fault, b_unc;
    logic [2:0]  b_ch_fail;
    tmr_mode_e   b_mode;
    logic [1:0]  b_err_cnt;

    cv32e40p_tmr_voter_mgr #(.WIDTH(32), .PERM_THRESH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .clear_i(clear_i),
        .in1_i(in1), .in2_i(in2), .in3_i(in3),
        .vote_o(vote), .fault_o(fault), .uncorrectable_o(unc),
        .ch_fail_o(ch_fail), .mode_o(mode), .err_cnt_o(err_cnt)
    );

    cv32e40p_tmr_voter_mgr #(.WIDTH(32), .PERM_THRESH(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .valid_i(b_valid), .clear_i(b_clear),
        .in1_i(b_in1), .in2_i(b_in2), .in3_i(b_in3),
        .vote_o(b_vote), .fault_o(b_fault), .uncorrectable_o(b_unc),
        .ch_fail_o(b_ch_fail), .mode_o(b_mode), .err_cnt_o(b_err_cnt)
    );

    typedef struct {
        logic [31:0] a, b, c;
        logic        v, clr;
        logic [31:0] e_vote;
        logic        e_fault;
        logic        e_unc;
        logic [2:0]  e_cf;
        logic [1:0]  e_mode;
        logic [7:0]  e_err;
    } vec_t;

    typedef struct {
        logic       unc;
        logic [2:0] cf;
        logic [1:0] mode;
        logic [7:0] err;
    } st_t;

    vec_t tbl[$];
    st_t  sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, b, c, input logic v, clr,
                                input logic [31:0] ev, input logic ef, eu,
                                input logic [2:0] ecf, input logic [1:0] em,
                                input logic [7:0] ee);
        vec_t r;
        r.a = a; r.b = b; r.c = c; r.v = v; r.clr = clr;
        r.e_vote = ev; r.e_fault = ef; r.e_unc = eu;
        r.e_cf = ecf; r.e_mode = em; r.e_err = ee;
        return r;
    endfunction

    // Drive one sample on the main DUT, check comb outputs mid-cycle, then the
    // registered status after the following edge via the scoreboard.
    task automatic apply(input vec_t t, input string tag);
        st_t e, got;
        @(negedge clk);
        in1 = t.a; in2 = t.b; in3 = t.c; valid_i = t.v; clear_i = t.clr;
        #1;
        chk({tag, "_vote"}, vote, t.e_vote);
        chk({tag, "_fault"}, 32'(fault), 32'(t.e_fault));
        e.unc = t.e_unc; e.cf = t.e_cf; e.mode = t.e_mode; e.err = t.e_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            chk({tag, "_unc"},  32'(unc),     32'(got.unc));
            chk({tag, "_cf"},   32'(ch_fail), 32'(got.cf));
            chk({tag, "_mode"}, 32'(mode),    32'(got.mode));
            chk({tag, "_err"},  32'(err_cnt), 32'(got.err));
        end
    endtask

    task automatic apply_b(input logic [31:0] a, b, c, input logic v,
                           input logic [31:0] ev, input logic ef, eu,
                           input logic [2:0] ecf, input logic [1:0] em,
                           input logic [1:0] ee, input string tag);
        @(negedge clk);
        b_in1 = a; b_in2 = b; b_in3 = c; b_valid = v;
        #1;
        chk({tag, "_vote"},  b_vote, ev);
        chk({tag, "_fault"}, 32'(b_fault), 32'(ef));
        @(posedge clk);
        #1;
        chk({tag, "_unc"},  32'(b_unc),     32'(eu));
        chk({tag, "_cf"},   32'(b_ch_fail), 32'(ecf));
        chk({tag, "_mode"}, 32'(b_mode),    32'(em));
        chk({tag, "_err"},  32'(b_err_cnt), 32'(ee));
    endtask

    localparam logic [1:0] MF = 2'b00, MD = 2'b01, MX = 2'b10;

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; clear_i = 1'b0;
        in1 = 32'h3; in2 = 32'h3; in3 = 32'h3;
        b_valid = 1'b0; b_clear = 1'b0; b_in1 = '0; b_in2 = '0; b_in3 = '0;

        //         a      b      c     v  clr  vote   flt unc cf      mode err
        tbl.push_back(mk(32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1, 0, 32'hA5A5_A5A5, 0, 0, 3'b000, MF, 0));
        for (int i = 1; i <= 3; i++) tbl.push_back(mk(0, 1, 0, 1, 0, 0, 1, 0, 3'b000, MF, 8'(i)));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 3'b000, MF, 3));
        for (int i = 4; i <= 6; i++) tbl.push_back(mk(0, 1, 0, 1, 0, 0, 1, 0, 3'b000, MF, 8'(i)));
        tbl.push_back(mk(0, 1, 2, 1, 0, 0, 1, 1, 3'b000, MF, 7));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 3'b000, MF, 7));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 1, 0, 3'b010, MD, 8));
        tbl.push_back(mk(7, 0, 7, 1, 0, 7, 0, 0, 3'b010, MD, 8));
        for (int i = 9; i <= 11; i++) tbl.push_back(mk(5, 9, 6, 1, 0, 5, 1, 1, 3'b010, MD, 8'(i)));
        tbl.push_back(mk(5, 9, 5, 1, 0, 5, 0, 0, 3'b010, MD, 11));
        for (int i = 12; i <= 14; i++) tbl.push_back(mk(5, 9, 6, 1, 0, 5, 1, 1, 3'b010, MD, 8'(i)));
        tbl.push_back(mk(5, 9, 6, 1, 0, 5, 1, 1, 3'b010, MX, 15));
        tbl.push_back(mk(3, 0, 4, 1, 0, 3, 1, 1, 3'b010, MX, 16));
        tbl.push_back(mk(3, 0, 4, 1, 1, 3, 1, 0, 3'b000, MF, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 1, 0, 3'b000, MF, 1));
        tbl.push_back(mk(32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0, 0, 32'hA5A5_A5A5, 0, 0, 3'b000, MF, 1));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_unc",  32'(unc), 32'd0);
        chk("rst_cf",   32'(ch_fail), 32'd0);
        chk("rst_mode", 32'(mode), 32'(MF));
        chk("rst_err",  32'(err_cnt), 32'd0);
        chk("rst_vote", vote, 32'h3);
        chk("rst_b_err", 32'(b_err_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("r%0d", i));

        // Reset mid-degradation: ch2 counter at 3, reset must wipe it
        apply(mk(0, 1, 0, 1, 0, 0, 1, 0, 3'b000, MF, 2), "pre_rst0");
        apply(mk(0, 1, 0, 1, 0, 0, 1, 0, 3'b000, MF, 3), "pre_rst1");
        @(negedge clk);
        rst_n = 1'b0; in1 = 0; in2 = 1; in3 = 0; valid_i = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_cf",   32'(ch_fail), 32'd0);
        chk("midrst_mode", 32'(mode), 32'(MF));
        chk("midrst_err",  32'(err_cnt), 32'd0);
        chk("midrst_unc",  32'(unc), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; valid_i = 1'b0;
        for (int i = 1; i <= 3; i++)
            apply(mk(0, 1, 0, 1, 0, 0, 1, 0, 3'b000, MF, 8'(i)), $sformatf("post_rst%0d", i));
        apply(mk(0, 1, 0, 1, 0, 0, 1, 0, 3'b010, MD, 4), "post_rst4");

        // PERM_THRESH=1, CNT_W=2 instance
        apply_b(0, 1, 0, 1, 0, 1, 0, 3'b010, MD, 1, "b0");
        apply_b(5, 0, 6, 1, 5, 1, 1, 3'b010, MX, 2, "b1");
        apply_b(5, 0, 6, 1, 5, 1, 1, 3'b010, MX, 3, "b2");
        apply_b(5, 0, 6, 1, 5, 1, 1, 3'b010, MX, 3, "b3");
        apply_b(5, 0, 6, 1, 5, 1, 1, 3'b010, MX, 3, "b4");
        apply_b(5, 0, 6, 0, 5, 1, 0, 3'b010, MX, 3, "b5");

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cv32e40p_tmr_voter_mgr.md
# cv32e40p_tmr_voter_mgr

Parametrised triple-modular-redundancy voter with fault bookkeeping. It sits between the three replicas of a TMR-protected execution unit and the pipeline. It produces a zero-latency voted result and tracks per-replica mismatch history. A replica that persistently disagrees is retired, and voting degrades TMR → DMR → FAIL. Detected faults become registered status that the controller consumes, instead of being an unmanaged internal flag.

## Interface
- WIDTH, 32, data width of each replica output
- PERM_THRESH, 4, consecutive attributed mismatches before a channel (or the DMR pair) is declared permanently faulty; legal range ≥1
- CNT_W, 8, width of saturating total-error counter
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- valid_i  in  1  inputs carry a real result this cycle; bookkeeping updates only when high
- clear_i  in  1  synchronous clear of all fault state (maintenance/scrub)
- in1_i, in2_i, in3_i  in  WIDTH  replica outputs
- vote_o  out  WIDTH  voted result, combinational
- fault_o  out  1  combinational: healthy channels disagree this cycle (independent of valid_i)
- uncorrectable_o  out  1  registered one-cycle pulse: last valid sample could not be corrected
- ch_fail_o  out  3  sticky per-channel retired flags
- mode_o  out  tmr_mode_e  current voting mode
- err_cnt_o  out  CNT_W  saturating count of valid cycles with fault_o high

## Operation
- Modes: TMR_FULL (no channel retired), TMR_DMR (exactly one retired), TMR_FAIL (pair untrustworthy).
- TMR_FULL vote: bitwise majority of in1..in3. Channel k "disagrees" if in_k ≠ vote. fault_o = any disagreement.
- Attribution: on valid_i, if exactly one channel disagrees, its mismatch counter increments (saturates at PERM_THRESH); the other two reset to 0. If no channel disagrees, all counters reset. If ≥2 disagree (multi-bit divergence), counters hold and uncorrectable_o pulses next cycle; vote_o is still the bitwise majority.
- A counter reaching PERM_THRESH sets that ch_fail bit. mode → TMR_DMR on the next edge. Counters clear.
- TMR_DMR: vote_o = lowest-index healthy channel. fault_o = the two healthy channels differ. Each valid mismatch pulses uncorrectable_o and increments a pair counter. Any valid match resets the pair counter. At PERM_THRESH, mode → TMR_FAIL.
- TMR_FAIL: vote_o = lowest-index healthy channel. fault_o is as in DMR. Each valid mismatch pulses uncorrectable_o. The block stays in FAIL until clear_i or reset.
- The retired channel is ignored for voting and fault_o in DMR/FAIL. ch_fail_o is never set for more than one channel.
- err_cnt_o increments on valid_i && fault_o and saturates at 2^CNT_W−1.
- clear_i: all counters, ch_fail_o, and err_cnt_o return to 0, and mode returns to TMR_FULL. clear_i has priority over same-cycle valid_i bookkeeping. vote_o/fault_o in that cycle still use the pre-clear mode.

## Timing
- vote_o, fault_o: 0-cycle combinational from in*_i and the current mode.
- Status (ch_fail_o, mode_o, err_cnt_o, uncorrectable_o): updated on the rising edge after the causing valid sample (1-cycle latency).
- Reset values: ch_fail_o=3'b000, mode_o=TMR_FULL, err_cnt_o=0, uncorrectable_o=0, all internal counters 0. vote_o/fault_o follow inputs under TMR_FULL.
- Reset asserted mid-degradation: the next edge forces the full reset state regardless of counters.
- The mode change takes effect for vote_o in the cycle after the threshold sample. The threshold sample itself is voted in the old mode.
- PERM_THRESH=1: a single attributed mismatch retires the channel.

## Structure
- cv32e40p_pkg: typedef enum logic [1:0] tmr_mode_e {TMR_FULL=2'b00, TMR_DMR=2'b01, TMR_FAIL=2'b10}.
- Sub-module: reuse the existing parametrised `voter` (bitwise majority + detect) for the TMR_FULL path. The DMR compare, attribution, counters, and mode FSM live in this block.

## Test plan
- Reset, then in1=in2=in3=32'hA5A5_A5A5 with valid → vote_o=A5A5_A5A5, fault_o=0, err_cnt_o=0, mode_o=TMR_FULL.
- in2=32'h0000_0001 and others 0 for 4 valid cycles → fault_o each cycle, vote_o=0. After the 4th edge: ch_fail_o=3'b010, mode_o=TMR_DMR, err_cnt_o=4.
- Same as above, but a matching sample after 3 mismatches → counter resets; a further 3 mismatches do not retire the channel.
- in1=0, in2=1, in3=2 (two disagree) with valid → vote_o=0, uncorrectable_o high for one cycle, counters unchanged.
- DMR with ch2 retired: in1=5, in3=6 for 4 valid cycles → vote_o=5, uncorrectable_o pulses each cycle, then mode_o=TMR_FAIL. Then clear_i → mode_o=TMR_FULL, ch_fail_o=0, err_cnt_o=0.
- CNT_W=2: 5 valid faulty cycles → err_cnt_o saturates at 3. Mismatches with valid_i=0 → no status change.
